// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction fetch front-end with a DEPTH-entry response FIFO and redirect flush.
// Optional feature macro FETCH_ALIGN_CHECK_EN adds the sticky fetch_misalign output.
module fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            rsp_valid,
  input  logic [XLEN-1:0] rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic            fetch_misalign
`endif
);

  localparam int unsigned      PTR_W   = $clog2(DEPTH);
  localparam int unsigned      CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
  localparam logic [CNT_W:0]   CREDITS = (CNT_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [XLEN-1:0]  r_fetch_pc;
  logic [XLEN-1:0]  r_rsp_pc;
  logic [XLEN-1:0]  r_pend_addr;
  logic             r_pend;
  logic             r_pend_stale;
  logic [CNT_W-1:0] r_occ;
  logic [CNT_W-1:0] r_out;
  logic [CNT_W-1:0] r_drop;
  logic [CNT_W-1:0] w_drop_nxt;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [XLEN-1:0]  r_fifo_data [DEPTH];
  logic [XLEN-1:0]  r_fifo_pc   [DEPTH];

  logic             w_fetch_block;
  logic [XLEN-1:0]  w_redirect_pc;
  logic [CNT_W:0]   w_credit_used;
  logic             w_raise;
  logic             w_accept;
  logic             w_hold;
  logic             w_push;
  logic             w_pop;

  assign w_redirect_pc = {redirect_pc[XLEN-1:2], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_misalign;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_misalign <= 1'b0;
    end else if (redirect) begin
      r_misalign <= (redirect_pc[1:0] != 2'b00);
    end
  end

  assign fetch_misalign = r_misalign;
  assign w_fetch_block  = r_misalign;
`else
  logic w_unused_pc_lsbs;
  assign w_unused_pc_lsbs = ^redirect_pc[1:0];
  assign w_fetch_block    = 1'b0;
`endif

  // Every buffered entry or in-flight response holds one credit, so a push can never find the FIFO full.
  assign w_credit_used = {1'b0, r_occ} + {1'b0, r_out};
  assign w_raise       = (r_state == S_FETCH) && !w_fetch_block && (w_credit_used < CREDITS);

  // A request that was raised but not taken keeps its original address, even across a redirect.
  assign req_valid = r_pend | w_raise;
  assign req_addr  = r_pend ? r_pend_addr : r_fetch_pc;
  assign w_accept  = req_valid & req_ready;
  assign w_hold    = req_valid & ~req_ready;

  assign w_push      = rsp_valid & ~redirect & (r_drop == '0);
  assign instr_valid = (r_occ != '0);
  assign w_pop       = instr_valid & instr_ready & ~redirect;
  assign instr       = r_fifo_data[r_rd_ptr];
  assign instr_pc    = r_fifo_pc[r_rd_ptr];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_drop_nxt = r_drop;
    if (redirect) begin
      w_drop_nxt = r_out + CNT_W'(req_valid) - CNT_W'(rsp_valid);
    end else if (rsp_valid && (r_drop != '0)) begin
      w_drop_nxt = r_drop - CNT_ONE;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:           w_state_nxt = S_FETCH;
      S_FETCH, S_DRAIN: w_state_nxt = (w_drop_nxt != '0) ? S_DRAIN : S_FETCH;
      default:          w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_fetch_pc   <= RESET_PC;
      r_rsp_pc     <= RESET_PC;
      r_pend_addr  <= RESET_PC;
      r_pend       <= 1'b0;
      r_pend_stale <= 1'b0;
      r_out        <= '0;
      r_drop       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_drop       <= w_drop_nxt;
      r_out        <= r_out + CNT_W'(w_accept) - CNT_W'(rsp_valid);
      r_pend       <= w_hold;
      r_pend_stale <= w_hold & (redirect | r_pend_stale);
      if (w_hold) begin
        r_pend_addr <= req_addr;
      end
      if (redirect) begin
        r_fetch_pc <= w_redirect_pc;
        r_rsp_pc   <= w_redirect_pc;
      end else begin
        // A stale request belongs to the abandoned stream and must not advance the new one.
        if (w_accept && !r_pend_stale) begin
          r_fetch_pc <= r_fetch_pc + PC_STEP;
        end
        if (w_push) begin
          r_rsp_pc <= r_rsp_pc + PC_STEP;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_occ    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (redirect) begin
      r_occ    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_occ <= r_occ + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // NOTE: FIFO storage is deliberately not reset; r_occ alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= rsp_data;
      r_fifo_pc[r_wr_ptr]   <= r_rsp_pc;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!(w_push && !w_pop && (r_occ == CNT_MAX)));
      assert (!(rsp_valid && (r_out == '0)));
    end
  end
`endif

endmodule
